// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and packed-port slicing helper for the register file
package regfile_pkg;
  localparam int REGFILE_DATA_W = 64;
  localparam int REGFILE_DEPTH = 32;
  function automatic int sliceBase(input int port, input int width);
    return port * width;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-write bits with reserve-over-write priority and per-port readiness
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH = REGFILE_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       regWrite,
  input  logic [ADDR_W-1:0]          writeReg,
  input  logic                       reserveEn,
  input  logic [ADDR_W-1:0]          reserveReg,
  input  logic [NUM_READ*ADDR_W-1:0] readReg,
  output logic [NUM_READ-1:0]        readyNext
);
  logic [DEPTH-1:0] pending, pendingNext;
  // Set after clear so a new producer overtakes the retiring one.
  always_comb begin
    pendingNext = pending;
    if (regWrite) pendingNext[writeReg] = 1'b0;
    if (reserveEn && !(ZERO_REG != 0 && reserveReg == '0)) pendingNext[reserveReg] = 1'b1;
    for (int i = 0; i < NUM_READ; i++)
      readyNext[i] = ~pendingNext[readReg[sliceBase(i, ADDR_W) +: ADDR_W]];
  end
  always_ff @(posedge clk) pending <= reset ? '0 : pendingNext;
endmodule

// File: rtl/register_file_sb.sv
// register_file_sb: parametrised register file with registered reads, write-first bypass,
// optional zero register and pending-write scoreboard
module register_file_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = REGFILE_DATA_W,
  parameter int DEPTH = REGFILE_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       regWrite,
  input  logic [ADDR_W-1:0]          writeReg,
  input  logic [DATA_W-1:0]          writeData,
  input  logic [NUM_READ-1:0]        readEn,
  input  logic [NUM_READ*ADDR_W-1:0] readReg,
  output logic [NUM_READ*DATA_W-1:0] readData,
  output logic [NUM_READ-1:0]        readValid,
  output logic [NUM_READ-1:0]        readReady,
  input  logic                       reserveEn,
  input  logic [ADDR_W-1:0]          reserveReg
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdNext [NUM_READ];
  logic [NUM_READ-1:0] readyNext;
  logic wrEn;
  assign wrEn = regWrite && !(ZERO_REG != 0 && writeReg == '0);
  regfile_scoreboard #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NUM_READ(NUM_READ), .ZERO_REG(ZERO_REG)) sb (
    .clk(clk),
    .reset(reset),
    .regWrite(regWrite),
    .writeReg(writeReg),
    .reserveEn(reserveEn),
    .reserveReg(reserveReg),
    .readReg(readReg),
    .readyNext(readyNext)
  );
  always_comb begin
    for (int i = 0; i < NUM_READ; i++) begin
      logic [ADDR_W-1:0] a;
      a = readReg[sliceBase(i, ADDR_W) +: ADDR_W];
      rdNext[i] = (ZERO_REG != 0 && a == '0) ? '0 : (wrEn && writeReg == a) ? writeData : mem[a];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
      readData <= '0;
      readValid <= '0;
      readReady <= '1;
    end else begin
      if (wrEn) mem[writeReg] <= writeData;
      readValid <= readEn;
      for (int i = 0; i < NUM_READ; i++)
        if (readEn[i]) begin
          readData[sliceBase(i, DATA_W) +: DATA_W] <= rdNext[i];
          readReady[i] <= readyNext[i];
        end
    end
  end
endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: directed checks of reads, bypass, zero register, scoreboard and reset
module tb_register_file_sb;
  logic clk = 0, reset, regWrite, reserveEn;
  logic [4:0] writeReg, reserveReg;
  logic [63:0] writeData;
  logic [1:0] readEn, readValid, readReady;
  logic [9:0] readReg;
  logic [127:0] readData;
  int total = 0, bad = 0;
  localparam logic [63:0] A = 64'h3762_35E0_1BB1_1AF2, B = 64'h1BB1_1AB1_4DD8_AD18;
  localparam logic [63:0] C = 64'hDEAD_BEEF_0000_0001, D = 64'h0BAD_F00D_CAFE_0005;
  localparam logic [63:0] E = 64'h0000_0000_0000_5555;
  always #5 clk = ~clk;
  register_file_sb dut (
    .clk(clk), .reset(reset), .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .readEn(readEn), .readReg(readReg), .readData(readData), .readValid(readValid),
    .readReady(readReady), .reserveEn(reserveEn), .reserveReg(reserveReg)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    regWrite = 0; reserveEn = 0; readEn = 0;
  endtask
  initial begin
    reset = 1; idle(); writeReg = 0; writeData = 0; readReg = 0; reserveReg = 0;
    tick(); tick();
    chk("rst_valid", readValid, 2'b00);
    chk("rst_data", readData, 0);
    chk("rst_ready", readReady, 2'b11);
    reset = 0;
    readEn = 2'b11; readReg = {5'd14, 5'd13};
    tick();
    chk("t1_valid", readValid, 2'b11);
    chk("t1_data", readData, 0);
    chk("t1_ready", readReady, 2'b11);
    idle(); regWrite = 1; writeReg = 13; writeData = A;
    tick();
    writeReg = 14; writeData = B;
    tick();
    idle(); readEn = 2'b11; readReg = {5'd14, 5'd13};
    tick();
    chk("t2_port0", readData[63:0], A);
    chk("t2_port1", readData[127:64], B);
    chk("t2_valid", readValid, 2'b11);
    idle();
    tick();
    chk("t2_idle_valid", readValid, 2'b00);
    chk("t2_hold", readData, {B, A});
    regWrite = 1; writeReg = 7; writeData = C; readEn = 2'b01; readReg = {5'd13, 5'd7};
    tick();
    chk("t3_bypass", readData[63:0], C);
    chk("t3_valid", readValid, 2'b01);
    idle(); regWrite = 1; writeReg = 0; writeData = '1; reserveEn = 1; reserveReg = 0;
    readEn = 2'b01; readReg = {5'd13, 5'd0};
    tick();
    chk("t4_zero_bypass", readData[63:0], 0);
    chk("t4_zero_ready", readReady[0], 1'b1);
    idle(); readEn = 2'b01;
    tick();
    chk("t4_zero_read", readData[63:0], 0);
    chk("t4_zero_ready2", readReady[0], 1'b1);
    idle(); reserveEn = 1; reserveReg = 5;
    tick();
    idle(); readEn = 2'b01; readReg = {5'd13, 5'd5};
    tick();
    chk("t5_pending", readReady[0], 1'b0);
    idle(); regWrite = 1; writeReg = 5; writeData = C; readEn = 2'b01;
    tick();
    chk("t5_wr_ready", readReady[0], 1'b1);
    chk("t5_wr_data", readData[63:0], C);
    idle(); regWrite = 1; writeReg = 5; writeData = D; reserveEn = 1; reserveReg = 5;
    tick();
    idle(); readEn = 2'b11; readReg = {5'd5, 5'd5};
    tick();
    chk("t5_resv_wins", readReady, 2'b00);
    chk("t5_multi", readData, {D, D});
    idle(); reserveEn = 1; reserveReg = 9;
    tick();
    idle(); regWrite = 1; writeReg = 9; writeData = 64'h1234;
    tick();
    idle(); reserveEn = 1; reserveReg = 9;
    tick();
    idle(); readEn = 2'b01; readReg = {5'd13, 5'd9};
    tick();
    chk("t6_pre_data", readData[63:0], 64'h1234);
    chk("t6_pre_ready", readReady[0], 1'b0);
    reset = 1; regWrite = 1; writeReg = 9; writeData = E; reserveEn = 1;
    tick();
    chk("t6_rst_valid", readValid, 2'b00);
    chk("t6_rst_data", readData, 0);
    chk("t6_rst_ready", readReady, 2'b11);
    reset = 0; idle(); readEn = 2'b11; readReg = {5'd13, 5'd9};
    tick();
    chk("t6_data", readData, 0);
    chk("t6_ready", readReady, 2'b11);
    chk("t6_valid", readValid, 2'b11);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
